hourglass_sort_collector: RTL and testbench

- Receiving end of the sorter's AXI-stream output (key/index beats).
- Consumes exactly NUMBER_OF_ELEMENTS beats per frame and rebuilds three parallel vectors: sorted keys, sorted original indices, and the rank of each original element.
- Presents one frame result until acknowledged, and flags protocol and sort violations.
- Sits between hourglass_sorting_module and any parallel consumer, for example a rank-based selector.

---
 rtl/hourglass_sort_collector.sv | 177 +++++++++++++++++
 tb/tb_hourglass_sort_collector.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hourglass_sort_collector.sv
// Collects one sorted frame from the sorter stream into parallel key/index/rank vectors.
// Define HOURGLASS_COLLECTOR_CHECK_EN to build the order/stability/index checkers.
module hourglass_sort_collector #(
  parameter int NUMBER_OF_ELEMENTS = 21,
  parameter int KEY_WIDTH          = 8,
  parameter int OUTPUT_INDEX_WIDTH = 5
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             flush,
  input  logic [KEY_WIDTH-1:0]                             axis_in_key,
  input  logic [OUTPUT_INDEX_WIDTH-1:0]                    axis_in_index,
  input  logic                                             axis_in_valid,
  output logic                                             axis_in_ready,
  output logic [NUMBER_OF_ELEMENTS*KEY_WIDTH-1:0]          out_keys,
  output logic [NUMBER_OF_ELEMENTS*OUTPUT_INDEX_WIDTH-1:0] out_indices,
  output logic [NUMBER_OF_ELEMENTS*OUTPUT_INDEX_WIDTH-1:0] out_ranks,
  output logic                                             result_valid,
  input  logic                                             result_ack,
  output logic                                             order_error,
  output logic                                             stability_error,
  output logic                                             index_error
);

  localparam int N  = NUMBER_OF_ELEMENTS;
  localparam int KW = KEY_WIDTH;
  localparam int IW = OUTPUT_INDEX_WIDTH;
  localparam logic [IW-1:0] LAST_BEAT = IW'(N - 1);
  localparam logic [IW:0]   N_EXT     = (IW + 1)'(N);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   count_q, count_d;
  logic [N*KW-1:0] keys_q, keys_d;
  logic [N*IW-1:0] indices_q, indices_d;
  logic [N*IW-1:0] ranks_q, ranks_d;
  logic            xfer;
  logic            in_range;

  assign axis_in_ready = (state_q == COLLECT);
  assign result_valid  = (state_q == HOLD);
  assign xfer          = axis_in_valid && axis_in_ready;
  assign in_range      = ({1'b0, axis_in_index} < N_EXT);
  assign out_keys      = keys_q;
  assign out_indices   = indices_q;
  assign out_ranks     = ranks_q;

  // A beat arriving together with flush is accepted but leaves no trace.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    keys_d    = keys_q;
    indices_d = indices_q;
    ranks_d   = ranks_q;
    if (flush) begin
      state_d = COLLECT;
      count_d = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (xfer) begin
            keys_d[int'(count_q)*KW +: KW]    = axis_in_key;
            indices_d[int'(count_q)*IW +: IW] = axis_in_index;
            if (in_range) begin
              ranks_d[int'(axis_in_index)*IW +: IW] = count_q;
            end
            if (count_q == LAST_BEAT) begin
              state_d = HOLD;
              count_d = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (result_ack) begin
            state_d = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= COLLECT;
      count_q   <= '0;
      keys_q    <= '0;
      indices_q <= '0;
      ranks_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      keys_q    <= keys_d;
      indices_q <= indices_d;
      ranks_q   <= ranks_d;
    end
  end

`ifdef HOURGLASS_COLLECTOR_CHECK_EN
  logic [N-1:0]  seen_q, seen_d;
  logic [KW-1:0] prev_key_q, prev_key_d;
  logic [IW-1:0] prev_index_q, prev_index_d;
  logic          order_q, order_d;
  logic          stability_q, stability_d;
  logic          index_q, index_d;
  logic          clear_flags;

  assign clear_flags     = flush || ((state_q == HOLD) && result_ack);
  assign order_error     = order_q;
  assign stability_error = stability_q;
  assign index_error     = index_q;

  // Neighbour comparisons only make sense once a previous beat of this frame exists.
  always_comb begin
    seen_d       = seen_q;
    prev_key_d   = prev_key_q;
    prev_index_d = prev_index_q;
    order_d      = order_q;
    stability_d  = stability_q;
    index_d      = index_q;
    if (clear_flags) begin
      seen_d      = '0;
      order_d     = 1'b0;
      stability_d = 1'b0;
      index_d     = 1'b0;
    end else if (xfer) begin
      prev_key_d   = axis_in_key;
      prev_index_d = axis_in_index;
      if (count_q != '0) begin
        if (axis_in_key < prev_key_q) begin
          order_d = 1'b1;
        end
        if ((axis_in_key == prev_key_q) && (axis_in_index < prev_index_q)) begin
          stability_d = 1'b1;
        end
      end
      if (!in_range) begin
        index_d = 1'b1;
      end else begin
        if (seen_q[axis_in_index]) begin
          index_d = 1'b1;
        end
        seen_d[axis_in_index] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen_q       <= '0;
      prev_key_q   <= '0;
      prev_index_q <= '0;
      order_q      <= 1'b0;
      stability_q  <= 1'b0;
      index_q      <= 1'b0;
    end else begin
      seen_q       <= seen_d;
      prev_key_q   <= prev_key_d;
      prev_index_q <= prev_index_d;
      order_q      <= order_d;
      stability_q  <= stability_d;
      index_q      <= index_d;
    end
  end
`else
  assign order_error     = 1'b0;
  assign stability_error = 1'b0;
  assign index_error     = 1'b0;
`endif

endmodule

// File: tb/tb_hourglass_sort_collector.sv
// Scoreboard bench for hourglass_sort_collector: a driver pushes expected frames, a monitor checks them.
module tb_hourglass_sort_collector;

  localparam int N  = 21;
  localparam int KW = 8;
  localparam int IW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [KW-1:0]     axis_in_key = '0;
  logic [IW-1:0]     axis_in_index = '0;
  logic              axis_in_valid = 1'b0;
  logic              axis_in_ready;
  logic [N*KW-1:0]   out_keys;
  logic [N*IW-1:0]   out_indices;
  logic [N*IW-1:0]   out_ranks;
  logic              result_valid;
  logic              result_ack = 1'b0;
  logic              order_error;
  logic              stability_error;
  logic              index_error;

  hourglass_sort_collector #(
    .NUMBER_OF_ELEMENTS(N),
    .KEY_WIDTH(KW),
    .OUTPUT_INDEX_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .axis_in_key(axis_in_key),
    .axis_in_index(axis_in_index),
    .axis_in_valid(axis_in_valid),
    .axis_in_ready(axis_in_ready),
    .out_keys(out_keys),
    .out_indices(out_indices),
    .out_ranks(out_ranks),
    .result_valid(result_valid),
    .result_ack(result_ack),
    .order_error(order_error),
    .stability_error(stability_error),
    .index_error(index_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] keys;
    logic [255:0] indices;
    logic [255:0] ranks;
    logic         ordErr;
    logic         stabErr;
    logic         idxErr;
  } expect_t;

  expect_t expQ[$];
  int checks = 0;
  int passes = 0;

  // Behavioural picture of what the consumer should see: slot arrays plus the frame being sent.
  int mKeys[N];
  int mIdx[N];
  int mRanks[N];
  int frameKeys[N];
  int frameIdx[N];

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  function automatic void modelReset();
    for (int i = 0; i < N; i++) begin
      mKeys[i] = 0;
      mIdx[i] = 0;
      mRanks[i] = 0;
    end
  endfunction

  function automatic expect_t buildExpected();
    expect_t e;
    int occurrences[32];
    e.keys = '0;
    e.indices = '0;
    e.ranks = '0;
    for (int j = 0; j < N; j++) begin
      e.keys[j*KW +: KW]    = KW'(mKeys[j]);
      e.indices[j*IW +: IW] = IW'(mIdx[j]);
      e.ranks[j*IW +: IW]   = IW'(mRanks[j]);
    end
    e.ordErr = 1'b0;
    e.stabErr = 1'b0;
    e.idxErr = 1'b0;
`ifdef HOURGLASS_COLLECTOR_CHECK_EN
    foreach (occurrences[v]) occurrences[v] = 0;
    for (int j = 0; j < N; j++) begin
      occurrences[frameIdx[j]]++;
      if (frameIdx[j] >= N || occurrences[frameIdx[j]] > 1) e.idxErr = 1'b1;
      if (j > 0 && frameKeys[j] < frameKeys[j-1]) e.ordErr = 1'b1;
      if (j > 0 && frameKeys[j] == frameKeys[j-1] && frameIdx[j] < frameIdx[j-1]) e.stabErr = 1'b1;
    end
`endif
    return e;
  endfunction

  // Random keys per original element, then order by (key, original index): a clean stable sort.
  task automatic buildSortedFrame(input int keyMax);
    int k[N];
    int ord[N];
    int tmp;
    for (int i = 0; i < N; i++) begin
      k[i] = $urandom_range(0, keyMax);
      ord[i] = i;
    end
    for (int a = 0; a < N - 1; a++) begin
      for (int b = 0; b < N - 1 - a; b++) begin
        if (k[ord[b]] > k[ord[b+1]] || (k[ord[b]] == k[ord[b+1]] && ord[b] > ord[b+1])) begin
          tmp = ord[b];
          ord[b] = ord[b+1];
          ord[b+1] = tmp;
        end
      end
    end
    for (int c = 0; c < N; c++) begin
      frameKeys[c] = k[ord[c]];
      frameIdx[c] = ord[c];
    end
  endtask

  task automatic buildRandomFrame();
    for (int c = 0; c < N; c++) begin
      frameKeys[c] = $urandom_range(0, 255);
      frameIdx[c] = $urandom_range(0, 31);
    end
  endtask

  // Sends frame beats 0..nBeats-1; call and return at a negedge.
  task automatic applyStimulus(input int nBeats, input int maxGap, input bit flushOnLast, input bit ackWhileCollecting);
    int gap;
    bit last;
    for (int c = 0; c < nBeats; c++) begin
      last = (c == nBeats - 1);
      gap = (maxGap == 0) ? 0 : $urandom_range(0, maxGap);
      repeat (gap) @(negedge clk);
      for (int t = 0; t < 50 && !axis_in_ready; t++) @(negedge clk);
      checkOutput("readyInCollect", 256'(axis_in_ready), 256'(1));
      axis_in_valid = 1'b1;
      axis_in_key   = KW'(frameKeys[c]);
      axis_in_index = IW'(frameIdx[c]);
      flush         = flushOnLast && last;
      result_ack    = ackWhileCollecting && !last;
      if (last && c == N - 1) checkOutput("validBeforeLast", 256'(result_valid), 256'(0));
      @(posedge clk);
      if (!(flushOnLast && last)) begin
        mKeys[c] = frameKeys[c];
        mIdx[c] = frameIdx[c];
        if (frameIdx[c] < N) mRanks[frameIdx[c]] = c;
        if (c == N - 1) expQ.push_back(buildExpected());
      end
      #1;
      axis_in_valid = 1'b0;
      flush = 1'b0;
      result_ack = 1'b0;
      if (last && c == N - 1) begin
        if (flushOnLast) begin
          checkOutput("flushBeatsCompletion", 256'(result_valid), 256'(0));
          checkOutput("readyAfterFlush", 256'(axis_in_ready), 256'(1));
        end else begin
          checkOutput("latencyValid", 256'(result_valid), 256'(1));
          checkOutput("readyLowInHold", 256'(axis_in_ready), 256'(0));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic ackResult(input int delay);
    for (int t = 0; t < 50 && !result_valid; t++) @(negedge clk);
    checkOutput("waitResult", 256'(result_valid), 256'(1));
    repeat (delay) begin
      @(negedge clk);
      checkOutput("holdReadyLow", 256'(axis_in_ready), 256'(0));
    end
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
    checkOutput("readyAfterAck", 256'(axis_in_ready), 256'(1));
    checkOutput("validAfterAck", 256'(result_valid), 256'(0));
    @(negedge clk);
  endtask

  // Monitor: pop on the first HOLD cycle, then require frozen outputs while held.
  logic         prevValid = 1'b0;
  logic [255:0] heldKeys, heldIdx, heldRanks;
  expect_t      monExp;
  always @(negedge clk) begin
    if (result_valid && !prevValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedResult", 256'(1), 256'(0));
      end else begin
        monExp = expQ.pop_front();
        checkOutput("outKeys", 256'(out_keys), monExp.keys);
        checkOutput("outIndices", 256'(out_indices), monExp.indices);
        checkOutput("outRanks", 256'(out_ranks), monExp.ranks);
        checkOutput("orderError", 256'(order_error), 256'(monExp.ordErr));
        checkOutput("stabilityError", 256'(stability_error), 256'(monExp.stabErr));
        checkOutput("indexError", 256'(index_error), 256'(monExp.idxErr));
      end
      heldKeys = 256'(out_keys);
      heldIdx = 256'(out_indices);
      heldRanks = 256'(out_ranks);
    end else if (result_valid && prevValid) begin
      checkOutput("stableKeys", 256'(out_keys), heldKeys);
      checkOutput("stableIndices", 256'(out_indices), heldIdx);
      checkOutput("stableRanks", 256'(out_ranks), heldRanks);
    end
    prevValid = result_valid;
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Keys"}, 256'(out_keys), 256'(0));
    checkOutput({tag, "Indices"}, 256'(out_indices), 256'(0));
    checkOutput({tag, "Ranks"}, 256'(out_ranks), 256'(0));
    checkOutput({tag, "Valid"}, 256'(result_valid), 256'(0));
    checkOutput({tag, "Ready"}, 256'(axis_in_ready), 256'(1));
    checkOutput({tag, "Flags"}, 256'({order_error, stability_error, index_error}), 256'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    #2 rst = 1'b0;
    #1 checkResetState("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Ascending 0..20, back-to-back beats.
    for (int c = 0; c < N; c++) begin
      frameKeys[c] = c;
      frameIdx[c] = c;
    end
    applyStimulus(N, 0, 1'b0, 1'b0);
    ackResult(1);

    // Order violation: 3,3,1,4,5,...
    for (int c = 0; c < N; c++) begin
      frameKeys[c] = c + 1;
      frameIdx[c] = c;
    end
    frameKeys[0] = 3;
    frameKeys[1] = 3;
    frameKeys[2] = 1;
    applyStimulus(N, 1, 1'b0, 1'b1);
    ackResult(0);

    // Stability violation: equal keys 2 carrying indices 7 then 4.
    for (int c = 0; c < N; c++) begin
      frameKeys[c] = c;
      frameIdx[c] = c;
    end
    frameKeys[0] = 0; frameKeys[1] = 0; frameKeys[2] = 1; frameKeys[3] = 1;
    frameKeys[4] = 2; frameKeys[5] = 2;
    frameIdx[4] = 7; frameIdx[5] = 4; frameIdx[6] = 5; frameIdx[7] = 6;
    applyStimulus(N, 0, 1'b0, 1'b0);
    ackResult(2);

    // Out-of-range index 25 and a repeated index 5.
    for (int c = 0; c < N; c++) begin
      frameKeys[c] = 2 * c;
      frameIdx[c] = c;
    end
    frameIdx[3] = 25;
    frameIdx[10] = 5;
    applyStimulus(N, 0, 1'b0, 1'b0);
    ackResult(0);

    // Flush after 10 beats, then a clean frame; ack withheld for 5 cycles.
    buildRandomFrame();
    applyStimulus(10, 1, 1'b0, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flushValid", 256'(result_valid), 256'(0));
    checkOutput("flushReady", 256'(axis_in_ready), 256'(1));
    @(negedge clk);
    buildSortedFrame(7);
    applyStimulus(N, 0, 1'b0, 1'b0);
    ackResult(5);

    // Flush arriving with the completing beat wins.
    buildSortedFrame(255);
    applyStimulus(N, 0, 1'b1, 1'b0);
    buildSortedFrame(3);
    applyStimulus(N, 2, 1'b0, 1'b0);
    ackResult(3);

    // Asynchronous reset during the frame, between clock edges.
    buildRandomFrame();
    applyStimulus(7, 0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    modelReset();
    #1 checkResetState("midReset");
    @(negedge clk);
    rst = 1'b1;
    buildSortedFrame(15);
    applyStimulus(N, 1, 1'b0, 1'b0);
    ackResult(1);

    // Randomized frames, clean and arbitrary.
    for (int f = 0; f < 6; f++) begin
      if (f % 2 == 0) buildRandomFrame();
      else buildSortedFrame($urandom_range(1, 40));
      applyStimulus(N, $urandom_range(0, 2), 1'b0, 1'(f == 3));
      ackResult($urandom_range(0, 4));
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboardDrained", 256'(expQ.size()), 256'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
